margin_batch_ctrl: RTL

//  Batch sequencer and argmin selector for the 10-class margin datapath (margin_pipeline10).
//  - Accepts NUM_SAMPLES score vectors through a valid/ready handshake and drives the pipeline enable.
//  - Tags each in-flight sample with its index and tracks the returned margins.
//  - Reports the index and margin of the least-confident (minimum-margin) sample of the batch.

---
 rtl/margin_pkg.sv | 21 ++
 rtl/margin_argmin.sv | 47 ++++
 rtl/margin_batch_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/margin_pkg.sv
// Shared types and defaults for the margin batch controller.
package margin_pkg;

  // Batch controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int MARGIN_PIPE_LAT    = 7;
  localparam int MARGIN_DATA_WIDTH  = 16;
  localparam int MARGIN_NUM_SAMPLES = 512;

  // Index width for a batch; a single-sample batch still gets one index bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/margin_argmin.sv
// Running minimum tracker: keeps the smallest margin seen and its sample index.
// Strict less-than compare, so ties keep the earliest index.
module margin_argmin #(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_W      = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init_i,
  input  logic                  upd_vld_i,
  input  logic [DATA_WIDTH-1:0] margin_i,
  input  logic [IDX_W-1:0]      idx_i,
  output logic [DATA_WIDTH-1:0] best_margin_o,
  output logic [IDX_W-1:0]      best_idx_o
);

  logic [DATA_WIDTH-1:0] best_margin_q, best_margin_d;
  logic [IDX_W-1:0]      best_idx_q, best_idx_d;

  // Next best: init wins, otherwise take a strictly smaller valid margin
  always_comb begin
    best_margin_d = best_margin_q;
    best_idx_d    = best_idx_q;
    if (init_i) begin
      best_margin_d = '1;
      best_idx_d    = '0;
    end else if (upd_vld_i && (margin_i < best_margin_q)) begin
      best_margin_d = margin_i;
      best_idx_d    = idx_i;
    end
  end

  // Best registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_margin_q <= '0;
      best_idx_q    <= '0;
    end else begin
      best_margin_q <= best_margin_d;
      best_idx_q    <= best_idx_d;
    end
  end

  assign best_margin_o = best_margin_q;
  assign best_idx_o    = best_idx_q;

endmodule

// File: rtl/margin_batch_ctrl.sv
// Batch sequencer for the 10-class margin pipeline: accepts NUM_SAMPLES
// vectors, tags them through the pipeline latency and reports the
// minimum-margin sample. Optional MARGIN_THRESH_EN adds a below-threshold
// counter (thresh / below_cnt ports).
module margin_batch_ctrl
  import margin_pkg::*;
#(
  parameter int  DATA_WIDTH  = MARGIN_DATA_WIDTH,
  parameter int  NUM_SAMPLES = MARGIN_NUM_SAMPLES,
  parameter int  PIPE_LAT    = MARGIN_PIPE_LAT,
  localparam int IDX_W       = idx_width(NUM_SAMPLES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  pipe_en,
  input  logic [DATA_WIDTH-1:0] pipe_margin,
  output logic                  busy,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [IDX_W-1:0]      res_idx,
  output logic [DATA_WIDTH-1:0] res_margin
`ifdef MARGIN_THRESH_EN
  ,
  input  logic [DATA_WIDTH-1:0] thresh,
  output logic [IDX_W:0]        below_cnt
`endif
);

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } tag_t;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      accept_cnt_q;
  tag_t [PIPE_LAT-1:0]   tag_q;
  tag_t                  tag_in;
  logic                  accept, last_accept, tag_any, batch_init, upd_vld;
  logic [DATA_WIDTH-1:0] best_margin;
  logic [IDX_W-1:0]      best_idx;
  logic [IDX_W-1:0]      res_idx_q;
  logic [DATA_WIDTH-1:0] res_margin_q;

  assign accept      = in_valid & in_ready;
  assign last_accept = accept && (accept_cnt_q == IDX_W'(NUM_SAMPLES - 1));
  assign batch_init  = (state_q == IDLE) && start;
  // Last tag lines up with pipe_margin only while the pipeline advances
  assign upd_vld     = pipe_en & tag_q[PIPE_LAT-1].vld;

  // Any sample still in flight
  always_comb begin
    tag_any = 1'b0;
    for (int i = 0; i < PIPE_LAT; i++) tag_any = tag_any | tag_q[i].vld;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    pipe_en  = 1'b0;
    unique case (state_q)
      IDLE:  if (start) state_d = RUN;
      RUN: begin
        in_ready = 1'b1;
        pipe_en  = 1'b1;
        if (last_accept) state_d = DRAIN;
      end
      DRAIN: begin
        pipe_en = 1'b1;
        if (!tag_any) state_d = DONE;
      end
      DONE:  if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Accept counter doubles as the tag index of the next sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          accept_cnt_q <= '0;
    else if (batch_init) accept_cnt_q <= '0;
    else if (accept)     accept_cnt_q <= accept_cnt_q + IDX_W'(1);
  end

  // Bubbles enter as invalid tags so their margins are never considered
  always_comb begin
    tag_in     = '0;
    tag_in.vld = accept;
    tag_in.idx = accept_cnt_q;
  end

  // Tag shift register mirrors the pipeline: advances only with pipe_en
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q <= '0;
    end else if (pipe_en) begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < PIPE_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  margin_argmin #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_argmin (
    .clk           (clk),
    .rst_n         (rst_n),
    .init_i        (batch_init),
    .upd_vld_i     (upd_vld),
    .margin_i      (pipe_margin),
    .idx_i         (tag_q[PIPE_LAT-1].idx),
    .best_margin_o (best_margin),
    .best_idx_o    (best_idx)
  );

  // Result snapshot on DONE entry so a later start cannot disturb it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_idx_q    <= '0;
      res_margin_q <= '0;
    end else if ((state_q == DRAIN) && (state_d == DONE)) begin
      res_idx_q    <= best_idx;
      res_margin_q <= best_margin;
    end
  end

`ifdef MARGIN_THRESH_EN
  logic [IDX_W:0] below_cnt_q;

  // Count valid margins under the threshold alongside the argmin update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               below_cnt_q <= '0;
    else if (batch_init)                      below_cnt_q <= '0;
    else if (upd_vld && (pipe_margin < thresh)) below_cnt_q <= below_cnt_q + (IDX_W+1)'(1);
  end

  assign below_cnt = below_cnt_q;
`endif

  assign busy       = (state_q != IDLE);
  assign res_valid  = (state_q == DONE);
  assign res_idx    = res_idx_q;
  assign res_margin = res_margin_q;

endmodule
